// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder : fixed-latency single-outstanding DMEM responder | rev 1.0
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int LATENCY    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  dmem_req_i,
   input  logic [DATA_WIDTH-1:0] dmem_addr_i,
   input  logic                  dmem_we_i,
   input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
   output logic [DATA_WIDTH-1:0] dmem_rd_o,
   output logic                  dmem_ack_o,
   output logic                  dmem_err_o,
   output logic                  busy_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   generate
      if (LATENCY < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
         $fatal(1, "dmem_responder: LATENCY must be >= 1 and DEPTH a power of two >= 2");
      end
   endgenerate

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  range_q, range_d;
   logic [DATA_WIDTH-1:0] rd_q, rd_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  w_in_range;
   logic                  w_commit;
   logic [IDX_W-1:0]      w_c_idx;
   logic                  w_c_we;
   logic [DATA_WIDTH-1:0] w_c_wdata;
   logic                  w_c_range;

   assign w_in_range = (dmem_addr_i[DATA_WIDTH-1:IDX_W] == '0);

   // A single-cycle latency commits on the capture edge, so it uses the live inputs.
   always_comb begin
      if (state_q == S_IDLE) begin
         w_c_idx   = dmem_addr_i[IDX_W-1:0];
         w_c_we    = dmem_we_i;
         w_c_wdata = dmem_wdata_i;
         w_c_range = w_in_range;
      end else begin
         w_c_idx   = idx_q;
         w_c_we    = we_q;
         w_c_wdata = wdata_q;
         w_c_range = range_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      range_d  = range_q;
      w_commit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dmem_req_i) begin
               idx_d   = dmem_addr_i[IDX_W-1:0];
               we_d    = dmem_we_i;
               wdata_d = dmem_wdata_i;
               range_d = w_in_range;
               cnt_d   = CNT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d  = S_RESP;
                  w_commit = 1'b1;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d  = S_RESP;
               w_commit = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ack_d  = w_commit;
      err_d  = w_commit && !w_c_range;
      busy_d = (state_d != S_IDLE);
      rd_d   = rd_q;
      if (w_commit && !w_c_we) begin
         rd_d = w_c_range ? mem_q[w_c_idx] : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         range_q <= 1'b0;
         rd_q    <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         range_q <= range_d;
         rd_q    <= rd_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   // Storage is never cleared; reset only blocks a pending store.
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_commit && w_c_we && w_c_range) begin
         mem_q[w_c_idx] <= w_c_wdata;
      end
   end

   assign dmem_rd_o  = rd_q;
   assign dmem_ack_o = ack_q;
   assign dmem_err_o = err_q;
   assign busy_o     = busy_q;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that terminates the execution unit's DMEM request interface (req/addr/we/wdata out, rdata/ack in).
- Holds a word-addressed register-file-style memory array.
- Accepts one request at a time, applies a fixed configurable access latency, then returns a single-cycle acknowledge, with read data for loads.
- Sits between the processor's execution stage and the data store; it is the only owner of DMEM contents.

Parameters:
- DATA_WIDTH, 32, width of address, write data and read data.
- DEPTH, 256, number of DATA_WIDTH-bit words; power of two, at least 2.
- LATENCY, 2, cycles from request capture to ack; at least 1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- dmem_req_i  input  1  request valid; initiator holds it, with addr/we/wdata, until it sees ack.
- dmem_addr_i  input  DATA_WIDTH  word address.
- dmem_we_i  input  1  1 = store, 0 = load.
- dmem_wdata_i  input  DATA_WIDTH  store data.
- dmem_rd_o  output  DATA_WIDTH  load data; valid when dmem_ack_o=1 for a load.
- dmem_ack_o  output  1  one-cycle completion pulse.
- dmem_err_o  output  1  asserted with ack when the address is out of range.
- busy_o  output  1  high while a request is in flight (states BUSY, RESP).

Behaviour:
- Reset:
  - Synchronous, active-high, with priority over all other logic.
  - State goes to IDLE; dmem_ack_o=0, dmem_err_o=0, dmem_rd_o=0, busy_o=0, latency counter=0.
  - Memory array is not cleared.
- Index and range check:
  - Index = addr[log2(DEPTH)-1:0].
  - The address is in range only when addr[DATA_WIDTH-1:log2(DEPTH)] is all zeros.
- FSM states: IDLE, BUSY, RESP.
  - IDLE:
    - If req_i=1, capture addr, we, wdata and the range flag into holding registers.
    - Load counter with LATENCY-1.
    - Go to RESP if LATENCY=1, otherwise go to BUSY.
    - If req_i=0, stay in IDLE.
  - BUSY:
    - Decrement counter each cycle; inputs are ignored, and only captured values are used.
    - Go to RESP on the edge where the counter value is 1.
  - RESP (exactly one cycle):
    - dmem_ack_o=1; dmem_err_o = NOT the range flag.
    - Always returns to IDLE next cycle.
- Latency: request sampled in IDLE at edge N gives ack high during the cycle following edge N+LATENCY-1. Ack is visible LATENCY cycles after capture.
- Access commit happens on the edge entering RESP, using the captured values:
  - Store in range: mem[index] <= wdata. dmem_rd_o is unchanged.
  - Load in range: dmem_rd_o <= mem[index].
  - Out of range: store is dropped; load sets dmem_rd_o <= 0.
- dmem_rd_o holds its last value outside load acks.
- Back-to-back requests:
  - IDLE samples again the cycle after RESP.
  - If req_i stays high continuously, a new request is captured every LATENCY+1 cycles.
  - Sustained throughput is 1 access per LATENCY+1 cycles.
- Read-after-write: a load following a store to the same index returns the new data, since the store commits before the load is captured.
- Input changes while in BUSY/RESP have no effect on the in-flight access.
- Reset mid-operation:
  - If rst_i=1 on the edge entering RESP, the store is not committed and no ack is issued.
  - The FSM returns to IDLE.
- Elaboration check: a fatal error if LATENCY<1 or DEPTH is not a power of two.
- Every output is a register; there is no combinational path from input to output.

Test Plan:
- Reset with LATENCY=2: hold rst_i=1 for 2 cycles while req_i=1 -> ack=0, busy=0, rd=0 throughout; no capture occurs.
- Store then load at LATENCY=2:
  - Store addr=5, wdata=0xDEADBEEF -> ack pulse 2 cycles after capture, err=0.
  - Load addr=5 -> ack with rd=0xDEADBEEF exactly 2 cycles after capture, ack width 1 cycle.
- Continuous req_i=1 loads at addr 0..3, preloaded with 0x10,0x11,0x12,0x13 -> acks every 3 cycles, rd sequence 0x10..0x13, and busy never low for more than 1 cycle.
- Out-of-range at DEPTH=256:
  - Store addr=0x100 with wdata=0x55 -> ack with err=1.
  - Load addr=0x000 -> returns the prior contents, not 0x55.
  - Load addr=0x100 -> rd=0, err=1.
- Input change mid-flight: capture store addr=7, wdata=0xA; change addr to 8 and wdata to 0xB during BUSY -> mem[7]=0xA and mem[8] unchanged.
- Reset mid-operation: capture store addr=3, wdata=0x77 (mem[3] was 0x01); assert rst_i on the commit edge -> no ack, and a later load of addr 3 returns 0x01.
- LATENCY=1 build: load addr=1 -> ack in the cycle immediately after capture.
